eq_fir_scheduler: RTL and testbench
===================================

Name: eq_fir_scheduler

Overview:
- Time-multiplexed FIR controller for the equalizer datapath, placed between the audio converter's received samples and its transmit samples.
- On each synchronized LRCK edge it captures that channel's input sample and shifts it into the channel's delay line.
- It then sequences one shared multiply-accumulate over TAPS coefficients read from an external synchronous coefficient memory, and writes a saturated 16-bit result per channel.
- Left and right share one coefficient set and one MAC.

Parameters:
- TAPS, 16, number of FIR taps (power of two, 4..64).
- DW, 16, sample width (signed).
- CW, 16, coefficient width (signed Q1.(CW-1)).
- ACCW, 36, accumulator width, at least DW+CW+log2(TAPS).

Ports:
- iCLK  in  1  system clock; all logic is on its rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iLRCK  in  1  audio LR clock, asynchronous to iCLK; high = left.
- iAUD_inL  in  DW  left input sample; stable around LRCK edges.
- iAUD_inR  in  DW  right input sample.
- iBYPASS  in  1  1 = pass samples through without filtering.
- oCOEF_ADDR  out  log2(TAPS)  coefficient memory read address.
- iCOEF  in  CW  coefficient data; valid 1 cycle after the address.
- oAUD_outL  out  DW  filtered left sample.
- oAUD_outR  out  DW  filtered right sample.
- oDONE_L  out  1  one-cycle pulse when oAUD_outL updates.
- oDONE_R  out  1  one-cycle pulse when oAUD_outR updates.
- oBUSY  out  1  high in any state other than IDLE.
- oOVERRUN  out  1  sticky; set when a pending sample is overwritten.

Behaviour:
- Reset (asynchronous, iRST_N=0) clears:
  - all outputs, delay lines, accumulator, pending flags and sync flops to 0;
  - state to IDLE.
  - Reset mid-operation abandons the computation; no done pulse is produced.
- LRCK synchronization:
  - 2-flop synchronizer plus a history flop.
  - Rising edge = left request; falling edge = right request.
  - The edge-detect cycle is cycle 0.
  - In cycle 0, iAUD_inL (rising) or iAUD_inR (falling) is latched into that channel's pending register and its pending flag is set.
- Pending conflicts:
  - If the same channel's pending flag is already set, the new sample overwrites it and oOVERRUN is set.
  - oOVERRUN clears only on reset.
- FSM states:
  - IDLE: if a pending flag is set, go to LOAD; left wins if both are set. Record the served channel; clear its pending flag on LOAD entry.
  - LOAD: shift the channel's delay line (x[0] <= sample, x[k] <= x[k-1]); acc <= 0; oCOEF_ADDR <= 0. Go to OUT if iBYPASS=1 (sampled here), else MAC.
  - MAC: exactly TAPS cycles, with oCOEF_ADDR = j in MAC cycle j, then incrementing. iCOEF returned in the following cycle is multiplied by x[j] through a one-cycle-delayed tap index. Accumulate from MAC cycle 1 onward.
  - FLUSH: 1 cycle; accumulates the last product (j = TAPS-1). Go to OUT.
  - OUT: compute the result and load the channel output register; the done pulse is registered; return to IDLE.
- Result arithmetic:
  - Filtered: result = acc >>> (CW-1), arithmetic shift truncating toward -inf, then saturated to [-2^(DW-1), 2^(DW-1)-1].
  - Bypass: result = x[0].
- Timing:
  - The new output value and its oDONE pulse are first visible in cycle TAPS+5 (filtered) or cycle 4 (bypass), counted from cycle 0.
  - oCOEF_ADDR holds its last value outside MAC.
- Throughput: one channel computation takes TAPS+4 cycles. With a 18.432 MHz iCLK and a 48 kHz LRCK, the 192-cycle half-frame budget is met for TAPS up to 64.
- Edges arriving while busy are queued via the pending flags, never dropped; only a second same-channel edge before service overruns.

Decomposition:
- Package eq_pkg holds:
  - the DW, CW and ACCW defaults;
  - the state enum (IDLE, LOAD, MAC, FLUSH, OUT);
  - the SAT_MAX/SAT_MIN constants;
  - the saturating-shift function.
- Sub-module lrck_edge_sync provides the 2-flop synchronizer plus rise/fall one-cycle pulses, with iCLK and iRST_N.
- Delay lines, MAC and FSM stay in eq_fir_scheduler.

Test Plan:
- Reset check: assert iRST_N=0 mid-MAC, then release. Required: all outputs 0, oBUSY=0, no oDONE; the next LRCK rising edge is served normally.
- Impulse response: coefficient memory h[k]=0x0400*(k+1); left input 0x4000 for one frame, 0 afterwards; right input 0.
  - Successive oAUD_outL values: 0x0200, 0x0400, ..., 0x2000, then 0x0000.
  - oAUD_outR stays 0x0000.
- Latency/addressing (TAPS=16): oDONE_L pulses exactly in cycle 21 after the synchronized rise detect. oCOEF_ADDR steps 0..15 on consecutive cycles.
- Saturation: all coefficients 0x7FFF.
  - Left input 0x7FFF for 16 frames: oAUD_outL=0x7FFF.
  - Left input 0x8000 for 16 frames: oAUD_outL=0x8000.
- Overrun: toggle iLRCK with a 10-cycle half-period. Required: oOVERRUN=1 and it stays 1; outputs correspond to the most recent pending samples.
- Bypass: iBYPASS=1, left input 0x1234. Required: oAUD_outL=0x1234 and oDONE_L in cycle 4; the delay line still shifts, so a filtered frame after bypass uses 0x1234 as x[1].

Source files
------------

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared widths, FSM states and result saturation for the equalizer FIR
package eq_pkg;

   localparam int EQ_DW   = 16;
   localparam int EQ_CW   = 16;
   localparam int EQ_ACCW = 36;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MAC   = 3'd2,
      FLUSH = 3'd3,
      OUT   = 3'd4
   } state_t;

   localparam logic signed [EQ_DW-1:0] SAT_MAX = {1'b0, {(EQ_DW-1){1'b1}}};
   localparam logic signed [EQ_DW-1:0] SAT_MIN = {1'b1, {(EQ_DW-1){1'b0}}};

   // Drop the Q1.(CW-1) fraction (floor toward -inf) and clamp to the sample range.
   function automatic logic signed [EQ_DW-1:0] sat_shift(input logic signed [EQ_ACCW-1:0] acc);
      logic signed [EQ_ACCW-1:0] sh;
      sh = acc >>> (EQ_CW-1);
      if (sh > EQ_ACCW'(SAT_MAX)) begin
         return SAT_MAX;
      end else if (sh < EQ_ACCW'(SAT_MIN)) begin
         return SAT_MIN;
      end else begin
         return sh[EQ_DW-1:0];
      end
   endfunction

endpackage

// File: rtl/lrck_edge_sync.sv
// rtl/lrck_edge_sync.sv - LRCK double-flop synchronizer with rise/fall request pulses
module lrck_edge_sync (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic iLRCK,
   output logic oRISE,
   output logic oFALL
);

   logic sync_1;
   logic sync_2;
   logic hist;

   // Two metastability flops followed by a history flop for edge detection.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         hist   <= 1'b0;
      end else begin
         sync_1 <= iLRCK;
         sync_2 <= sync_1;
         hist   <= sync_2;
      end
   end

   assign oRISE = sync_2 & ~hist;
   assign oFALL = ~sync_2 & hist;

endmodule

// File: rtl/eq_fir_scheduler.sv
// rtl/eq_fir_scheduler.sv - time-multiplexed stereo FIR scheduler with one shared MAC
module eq_fir_scheduler
   import eq_pkg::*;
#(
   parameter int TAPS = 16,
   parameter int DW   = EQ_DW,
   parameter int CW   = EQ_CW,
   parameter int ACCW = EQ_ACCW
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   input  logic                    iLRCK,
   input  logic [DW-1:0]           iAUD_inL,
   input  logic [DW-1:0]           iAUD_inR,
   input  logic                    iBYPASS,
   output logic [$clog2(TAPS)-1:0] oCOEF_ADDR,
   input  logic [CW-1:0]           iCOEF,
   output logic [DW-1:0]           oAUD_outL,
   output logic [DW-1:0]           oAUD_outR,
   output logic                    oDONE_L,
   output logic                    oDONE_R,
   output logic                    oBUSY,
   output logic                    oOVERRUN
);

   localparam int AW = $clog2(TAPS);
   localparam logic [AW-1:0] LAST_TAP = AW'(TAPS-1);

   logic                   rise;
   logic                   fall;
   state_t                 state;
   state_t                 nxt;
   logic                   pend_l;
   logic                   pend_r;
   logic [DW-1:0]          pend_smp_l;
   logic [DW-1:0]          pend_smp_r;
   logic signed [DW-1:0]   cur_smp;
   logic                   ch_r;
   logic                   byp;
   logic                   prod_vld;
   logic [AW-1:0]          tap_d;
   logic signed [DW-1:0]   xl [TAPS];
   logic signed [DW-1:0]   xr [TAPS];
   logic signed [ACCW-1:0] acc;
   logic signed [DW+CW-1:0] prod;
   logic signed [DW-1:0]   x_tap;
   logic signed [DW-1:0]   x_head;
   logic signed [DW-1:0]   result;
   logic                   take_l;
   logic                   take_r;
   logic                   st_idle;
   logic                   st_load;
   logic                   st_mac;
   logic                   st_flush;
   logic                   st_out;

   lrck_edge_sync u_sync (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iLRCK  (iLRCK),
      .oRISE  (rise),
      .oFALL  (fall)
   );

   // Service arbitration and MAC operand/result selection.
   always_comb begin
      take_l = st_idle && pend_l;
      take_r = st_idle && !pend_l && pend_r;
      x_tap  = ch_r ? xr[tap_d] : xl[tap_d];
      x_head = ch_r ? xr[0] : xl[0];
      prod   = $signed(iCOEF) * x_tap;
      result = byp ? x_head : sat_shift(acc);
   end

   // Pending sample registers; a second same-channel edge before service is an overrun.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         pend_l     <= 1'b0;
         pend_r     <= 1'b0;
         pend_smp_l <= '0;
         pend_smp_r <= '0;
         oOVERRUN   <= 1'b0;
      end else begin
         if (rise) begin
            pend_smp_l <= iAUD_inL;
            pend_l     <= 1'b1;
         end else if (take_l) begin
            pend_l <= 1'b0;
         end
         if (fall) begin
            pend_smp_r <= iAUD_inR;
            pend_r     <= 1'b1;
         end else if (take_r) begin
            pend_r <= 1'b0;
         end
         if ((rise && pend_l && !take_l) || (fall && pend_r && !take_r)) begin
            oOVERRUN <= 1'b1;
         end
      end
   end

   // Latch the served channel and its sample when leaving IDLE.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         ch_r    <= 1'b0;
         cur_smp <= '0;
      end else if (take_l || take_r) begin
         ch_r    <= take_r;
         cur_smp <= take_l ? pend_smp_l : pend_smp_r;
      end
   end

   // Shift the served channel's delay line once per request, bypassed or not.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int k = 0; k < TAPS; k++) begin
            xl[k] <= '0;
            xr[k] <= '0;
         end
      end else if (st_load) begin
         if (ch_r) begin
            xr[0] <= cur_smp;
            for (int k = 1; k < TAPS; k++) begin
               xr[k] <= xr[k-1];
            end
         end else begin
            xl[0] <= cur_smp;
            for (int k = 1; k < TAPS; k++) begin
               xl[k] <= xl[k-1];
            end
         end
      end
   end

   // Coefficient addressing and accumulation; memory data lags the address by one cycle.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         acc        <= '0;
         oCOEF_ADDR <= '0;
         tap_d      <= '0;
         prod_vld   <= 1'b0;
         byp        <= 1'b0;
      end else if (st_load) begin
         acc        <= '0;
         oCOEF_ADDR <= '0;
         prod_vld   <= 1'b0;
         byp        <= iBYPASS;
      end else if (st_mac) begin
         if (oCOEF_ADDR != LAST_TAP) begin
            oCOEF_ADDR <= oCOEF_ADDR + AW'(1);
         end
         tap_d    <= oCOEF_ADDR;
         prod_vld <= 1'b1;
         if (prod_vld) begin
            acc <= acc + ACCW'(prod);
         end
      end else if (st_flush) begin
         acc <= acc + ACCW'(prod);
      end
   end

   // Output registers and their one-cycle done pulses.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oAUD_outL <= '0;
         oAUD_outR <= '0;
         oDONE_L   <= 1'b0;
         oDONE_R   <= 1'b0;
      end else begin
         oDONE_L <= 1'b0;
         oDONE_R <= 1'b0;
         if (st_out) begin
            if (ch_r) begin
               oAUD_outR <= result;
               oDONE_R   <= 1'b1;
            end else begin
               oAUD_outL <= result;
               oDONE_L   <= 1'b1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (pend_l || pend_r) nxt = LOAD;
         LOAD:    nxt = iBYPASS ? OUT : MAC;
         MAC:     if (oCOEF_ADDR == LAST_TAP) nxt = FLUSH;
         FLUSH:   nxt = OUT;
         OUT:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // FSM state decodes.
   always_comb begin
      st_idle  = (state == IDLE);
      st_load  = (state == LOAD);
      st_mac   = (state == MAC);
      st_flush = (state == FLUSH);
      st_out   = (state == OUT);
      oBUSY    = !st_idle;
   end

endmodule

// File: tb/tb_eq_fir_scheduler.sv
// tb/tb_eq_fir_scheduler.sv - scoreboard bench for eq_fir_scheduler
module tb_eq_fir_scheduler;

   localparam int TAPS = 16;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        iLRCK = 1'b0;
   logic        iBYPASS = 1'b0;
   logic [15:0] iAUD_inL = '0;
   logic [15:0] iAUD_inR = '0;
   logic [15:0] iCOEF;
   logic [3:0]  oCOEF_ADDR;
   logic [15:0] oAUD_outL;
   logic [15:0] oAUD_outR;
   logic        oDONE_L;
   logic        oDONE_R;
   logic        oBUSY;
   logic        oOVERRUN;

   logic [15:0] coef [TAPS];
   int          hl [TAPS];
   int          hr [TAPS];
   logic [15:0] q_l [$];
   logic [15:0] q_r [$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   eq_fir_scheduler dut (
      .iCLK       (iCLK),
      .iRST_N     (iRST_N),
      .iLRCK      (iLRCK),
      .iAUD_inL   (iAUD_inL),
      .iAUD_inR   (iAUD_inR),
      .iBYPASS    (iBYPASS),
      .oCOEF_ADDR (oCOEF_ADDR),
      .iCOEF      (iCOEF),
      .oAUD_outL  (oAUD_outL),
      .oAUD_outR  (oAUD_outR),
      .oDONE_L    (oDONE_L),
      .oDONE_R    (oDONE_R),
      .oBUSY      (oBUSY),
      .oOVERRUN   (oOVERRUN)
   );

   always #5 iCLK = ~iCLK;

   // synchronous coefficient memory, one cycle read latency
   always @(posedge iCLK) iCOEF <= coef[oCOEF_ADDR];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // reference: plain convolution over each channel's sample history
   function automatic logic [15:0] model(input bit right, input logic [15:0] s, input bit byp);
      longint sum;
      longint y;
      sum = 0;
      for (int k = TAPS-1; k > 0; k--) begin
         if (right) hr[k] = hr[k-1];
         else       hl[k] = hl[k-1];
      end
      if (right) hr[0] = int'($signed(s));
      else       hl[0] = int'($signed(s));
      if (byp) return s;
      for (int k = 0; k < TAPS; k++) begin
         sum += longint'($signed(coef[k])) * longint'(right ? hr[k] : hl[k]);
      end
      y = sum >>> 15;
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      return y[15:0];
   endfunction

   task automatic clear_model();
      for (int k = 0; k < TAPS; k++) begin
         hl[k] = 0;
         hr[k] = 0;
      end
      q_l.delete();
      q_r.delete();
   endtask

   // monitor: pop and compare whenever a done pulse is presented
   always @(negedge iCLK) begin
      if (mon_en) begin
         if (oDONE_L) begin
            if (q_l.size() == 0) check("done_l_unexpected", {31'd0, oDONE_L}, 32'd0);
            else                 check("out_l", {16'd0, oAUD_outL}, {16'd0, q_l.pop_front()});
         end
         if (oDONE_R) begin
            if (q_r.size() == 0) check("done_r_unexpected", {31'd0, oDONE_R}, 32'd0);
            else                 check("out_r", {16'd0, oAUD_outR}, {16'd0, q_r.pop_front()});
         end
      end
   end

   task automatic lr_edge(input bit right, input logic [15:0] s, input bit byp);
      @(posedge iCLK);
      #1;
      iBYPASS = byp;
      if (right) begin
         iAUD_inR = s;
         q_r.push_back(model(1'b1, s, byp));
         iLRCK = 1'b0;
      end else begin
         iAUD_inL = s;
         q_l.push_back(model(1'b0, s, byp));
         iLRCK = 1'b1;
      end
   endtask

   task automatic frame(input logic [15:0] l, input logic [15:0] r, input bit byp, input int half);
      lr_edge(1'b0, l, byp);
      repeat (half) @(posedge iCLK);
      lr_edge(1'b1, r, byp);
      repeat (half) @(posedge iCLK);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_l.size() != 0 || q_r.size() != 0 || oBUSY) && n < 500) begin
         @(negedge iCLK);
         n++;
      end
      check("drain_pending", q_l.size() + q_r.size(), 32'd0);
   endtask

   // left edge with cycle-exact observation; cycle n counts clock edges after the LRCK change
   task automatic timed_left(input logic [15:0] s, input bit byp, input int exp_n);
      int done_n;
      done_n = -1;
      lr_edge(1'b0, s, byp);
      for (int n = 1; n <= 40; n++) begin
         @(posedge iCLK);
         @(negedge iCLK);
         if (!byp && n >= 5 && n <= 20) check("coef_addr_step", {28'd0, oCOEF_ADDR}, n - 5);
         if (oDONE_L && done_n < 0) done_n = n;
      end
      check("done_l_cycle", done_n, exp_n);
      lr_edge(1'b1, 16'h0000, byp);
      repeat (30) @(posedge iCLK);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_outl"}, {16'd0, oAUD_outL}, 32'd0);
      check({tag, "_outr"}, {16'd0, oAUD_outR}, 32'd0);
      check({tag, "_done"}, {30'd0, oDONE_L, oDONE_R}, 32'd0);
      check({tag, "_busy"}, {31'd0, oBUSY}, 32'd0);
      check({tag, "_overrun"}, {31'd0, oOVERRUN}, 32'd0);
      check({tag, "_addr"}, {28'd0, oCOEF_ADDR}, 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] last_l;
      logic [15:0] last_r;
      longint      yl;
      longint      yr;

      for (int k = 0; k < TAPS; k++) coef[k] = 16'(16'h0400 * (k + 1));
      clear_model();

      // reset state
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check_reset_outputs("reset");
      @(posedge iCLK);
      #1 iRST_N = 1'b1;
      mon_en = 1'b1;
      repeat (5) @(posedge iCLK);

      // impulse: first frame also measures latency and addressing
      timed_left(16'h4000, 1'b0, TAPS + 7);
      check("impulse_0", {16'd0, oAUD_outL}, 32'h0200);
      for (int n = 1; n <= 16; n++) begin
         frame(16'h0000, 16'h0000, 1'b0, 30);
         check("impulse_n", {16'd0, oAUD_outL}, (n < 16) ? 32'(16'h0200 * (n + 1)) : 32'd0);
         check("impulse_r", {16'd0, oAUD_outR}, 32'd0);
      end
      drain();

      // bypass, then a filtered frame sees the bypassed sample as x[1]
      timed_left(16'h1234, 1'b1, 6);
      check("bypass_out", {16'd0, oAUD_outL}, 32'h1234);
      frame(16'h0000, 16'h0000, 1'b0, 30);
      check("after_bypass", {16'd0, oAUD_outL}, 32'h0123);
      drain();

      // saturation at both rails
      for (int k = 0; k < TAPS; k++) coef[k] = 16'h7FFF;
      for (int n = 0; n < 16; n++) frame(16'h7FFF, 16'($urandom), 1'b0, 30);
      check("sat_pos", {16'd0, oAUD_outL}, 32'h7FFF);
      for (int n = 0; n < 16; n++) frame(16'h8000, 16'($urandom), 1'b0, 30);
      check("sat_neg", {16'd0, oAUD_outL}, 32'h8000);
      drain();

      // randomized frames over several coefficient sets
      for (int set = 0; set < 3; set++) begin
         for (int k = 0; k < TAPS; k++) coef[k] = 16'($urandom) >> set;
         for (int n = 0; n < 25; n++) begin
            frame(16'($urandom), 16'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(26, 45));
         end
         drain();
      end

      // reset in the middle of a MAC sequence
      lr_edge(1'b0, 16'h5555, 1'b0);
      repeat (10) @(posedge iCLK);
      #1;
      iRST_N = 1'b0;
      iLRCK  = 1'b0;
      clear_model();
      @(negedge iCLK);
      check_reset_outputs("midmac_reset");
      @(posedge iCLK);
      #1 iRST_N = 1'b1;
      repeat (40) @(posedge iCLK);
      @(negedge iCLK);
      check("post_reset_busy", {31'd0, oBUSY}, 32'd0);
      check("post_reset_outl", {16'd0, oAUD_outL}, 32'd0);
      frame(16'($urandom), 16'($urandom), 1'b0, 30);
      drain();

      // overrun: LRCK far faster than the schedule can follow
      mon_en = 1'b0;
      for (int k = 0; k < TAPS; k++) coef[k] = (k == 0) ? 16'h7FFF : 16'h0000;
      iBYPASS = 1'b0;
      check("overrun_before", {31'd0, oOVERRUN}, 32'd0);
      last_l = '0;
      last_r = '0;
      for (int i = 0; i < 40; i++) begin
         repeat (10) @(posedge iCLK);
         #1;
         if (!iLRCK) begin
            last_l = 16'($urandom);
            iAUD_inL = last_l;
         end else begin
            last_r = 16'($urandom);
            iAUD_inR = last_r;
         end
         iLRCK = ~iLRCK;
      end
      repeat (12) @(posedge iCLK);
      @(negedge iCLK);
      check("overrun_set", {31'd0, oOVERRUN}, 32'd1);
      repeat (100) @(posedge iCLK);
      @(negedge iCLK);
      check("overrun_sticky", {31'd0, oOVERRUN}, 32'd1);
      check("overrun_idle", {31'd0, oBUSY}, 32'd0);
      yl = (longint'($signed(last_l)) * 32767) >>> 15;
      yr = (longint'($signed(last_r)) * 32767) >>> 15;
      check("overrun_latest_l", {16'd0, oAUD_outL}, {16'd0, yl[15:0]});
      check("overrun_latest_r", {16'd0, oAUD_outR}, {16'd0, yr[15:0]});

      // only reset clears the sticky flag
      @(posedge iCLK);
      #1 iRST_N = 1'b0;
      @(negedge iCLK);
      check_reset_outputs("final_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
